// File: rtl/alu_op_feeder.sv
// Command FIFO and issue sequencer for a registered ALU: queues operand/opcode commands, drives
// them into the ALU one per cycle and returns each result as a one-cycle response, in order.
module alu_op_feeder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_sel,
  input  logic        pause,
  input  logic        flush,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [3:0]  ALU_Sel,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic [15:0] op_count,
  output logic [7:0]  err_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StPaused} state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } cmd_t;

  cmd_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  state_e          state_q;

  logic [7:0]  a_q, b_q;
  logic [3:0]  sel_q;
  logic        tag1_valid_q, tag1_err_q, tag2_valid_q, tag2_err_q;
  logic        rsp_valid_q, rsp_carry_q, rsp_err_q;
  logic [7:0]  rsp_data_q;
  logic [15:0] op_count_q;
  logic [7:0]  err_count_q;

  cmd_t head;
  logic full, empty, push, issue, head_err;

  always_comb begin
    full      = (cnt_q == CntW'(DEPTH));
    empty     = (cnt_q == '0);
    cmd_ready = !full && !flush && !reset;
    push      = cmd_valid && cmd_ready;
    // Issuing happens only once the FSM sits in StIssue, so leaving StPaused costs one cycle.
    issue     = (state_q == StIssue) && !empty && !pause && !flush;
    head      = mem_q[rd_ptr_q];
    head_err  = (head.sel > 4'd3) || ((head.sel == 4'd3) && (head.b == 8'd0));
    cnt_d     = cnt_q;
    if (push && !issue) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push && issue) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_sel};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      tag1_valid_q <= 1'b0;
      tag1_err_q   <= 1'b0;
      tag2_valid_q <= 1'b0;
      tag2_err_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
      err_count_q  <= '0;
    end else if (flush) begin
      state_q      <= pause ? StPaused : StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      tag1_valid_q <= 1'b0;
      tag1_err_q   <= 1'b0;
      tag2_valid_q <= 1'b0;
      tag2_err_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (issue) begin
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
        a_q        <= head.a;
        b_q        <= head.b;
        sel_q      <= head.sel;
        op_count_q <= op_count_q + 16'd1;
        if (head_err && (err_count_q != 8'hFF)) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end
      cnt_q        <= cnt_d;
      tag1_valid_q <= issue;
      tag1_err_q   <= issue && head_err;
      // The ALU registers its result on the edge the tag moves to stage 2.
      tag2_valid_q <= tag1_valid_q;
      tag2_err_q   <= tag1_err_q;
      rsp_valid_q  <= tag2_valid_q;
      if (tag2_valid_q) begin
        rsp_data_q  <= tag2_err_q ? 8'h00 : alu_result;
        rsp_carry_q <= tag2_err_q ? 1'b0 : alu_carry;
        rsp_err_q   <= tag2_err_q;
      end
      if (pause) begin
        state_q <= StPaused;
      end else if (cnt_d != '0) begin
        state_q <= StIssue;
      end else begin
        state_q <= StIdle;
      end
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign ALU_Sel   = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;
  assign err_count = err_count_q;

endmodule
